hit_resolver: RTL

HIT_RESOLVER -- requirements
Module: hit_resolver

---
 rtl/char_pkg.sv | 40 ++++
 rtl/hit_resolver_hit_detect.sv | 39 +++
 rtl/hit_resolver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/char_pkg.sv
// Shared character definitions: FSM state codes, winner codes and stun defaults.
// The character FSM and the hit resolver both import this package.
package char_pkg;

    typedef enum logic [3:0] {
        ST_IDLE            = 4'b0000,
        ST_NEUTRAL_STARTUP = 4'b0011,
        ST_NEUTRAL_ACTIVE  = 4'b0100,
        ST_DIR_STARTUP     = 4'b0110,
        ST_DIR_ACTIVE      = 4'b0111
    } char_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    typedef enum logic {
        G_RUN  = 1'b0,
        G_OVER = 1'b1
    } game_state_t;

    localparam logic [4:0] DEF_HIT_STUN   = 5'd16;
    localparam logic [4:0] DEF_BLOCK_STUN = 5'd8;
    localparam logic [4:0] COUNTER_BONUS  = 5'd4;

    function automatic logic is_startup(input logic [3:0] s);
        return (s == ST_NEUTRAL_STARTUP) || (s == ST_DIR_STARTUP);
    endfunction

    // Stun counts are 5 bits wide, so bonuses clamp at 31 instead of wrapping.
    function automatic logic [4:0] sat_add5(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[5] ? 5'd31 : sum[4:0];
    endfunction

endpackage

// File: rtl/hit_resolver_hit_detect.sv
// hit_detect: one attacker -> defender direction. Decodes the attacker's active
// state, compares distance against that attack's range and enforces one hit per attack.
module hit_detect
    import char_pkg::*;
#(
    parameter logic [9:0] ATTACK_RANGE = 10'd48,
    parameter logic [9:0] DIR_RANGE    = 10'd64
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       enable,
    input  logic       running,
    input  logic [3:0] state_atk,
    input  logic [9:0] distance,
    output logic       hit
);

    logic active;
    logic in_range;
    logic hit_done;

    assign active   = (state_atk == ST_NEUTRAL_ACTIVE) || (state_atk == ST_DIR_ACTIVE);
    assign in_range = (state_atk == ST_DIR_ACTIVE) ? (distance <= DIR_RANGE)
                                                   : (distance <= ATTACK_RANGE);
    assign hit      = enable && running && active && in_range && !hit_done;

    // hit_done re-arms as soon as the attacker leaves its active state or gameplay pauses.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            hit_done <= 1'b0;
        end else if (!enable || !active) begin
            hit_done <= 1'b0;
        end else if (hit) begin
            hit_done <= 1'b1;
        end
    end

endmodule

// File: rtl/hit_resolver.sv
// hit_resolver: resolves P1/P2 hits into stun pulses, health and the RUN/OVER game FSM.
// Optional macro HIT_RESOLVER_COUNTER_HIT_EN adds a stun bonus for counter hits on startup states.
module hit_resolver
    import char_pkg::*;
#(
    parameter logic [9:0] ATTACK_RANGE = 10'd48,
    parameter logic [9:0] DIR_RANGE    = 10'd64,
    parameter logic [4:0] HIT_STUN     = DEF_HIT_STUN,
    parameter logic [4:0] BLOCK_STUN   = DEF_BLOCK_STUN,
    parameter logic [1:0] MAX_HEALTH   = 2'd3
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       ENABLE,
    input  logic [3:0] STATE_P1,
    input  logic [3:0] STATE_P2,
    input  logic [9:0] POS_P1,
    input  logic [9:0] POS_P2,
    input  logic       BLOCK_P1,
    input  logic       BLOCK_P2,
    output logic [4:0] LOAD_FRAME_P1,
    output logic [4:0] LOAD_FRAME_P2,
    output logic [1:0] HEALTH_P1,
    output logic [1:0] HEALTH_P2,
    output logic       GAME_OVER,
    output logic [1:0] WINNER
);

    game_state_t state, state_nxt;
    logic [9:0]  distance;
    logic        running;
    logic        hit_on_p1, hit_on_p2;
    logic        counter_p1, counter_p2;
    logic [4:0]  stun_p1, stun_p2;
    logic [1:0]  health_p1_nxt, health_p2_nxt;

    assign distance = (POS_P1 >= POS_P2) ? (POS_P1 - POS_P2) : (POS_P2 - POS_P1);
    assign running  = (state == G_RUN);

    hit_detect #(.ATTACK_RANGE(ATTACK_RANGE), .DIR_RANGE(DIR_RANGE)) u_detect_p1_on_p2 (
        .CLOCK    (CLOCK),
        .RESET_N  (RESET_N),
        .enable   (ENABLE),
        .running  (running),
        .state_atk(STATE_P1),
        .distance (distance),
        .hit      (hit_on_p2)
    );

    hit_detect #(.ATTACK_RANGE(ATTACK_RANGE), .DIR_RANGE(DIR_RANGE)) u_detect_p2_on_p1 (
        .CLOCK    (CLOCK),
        .RESET_N  (RESET_N),
        .enable   (ENABLE),
        .running  (running),
        .state_atk(STATE_P2),
        .distance (distance),
        .hit      (hit_on_p1)
    );

`ifdef HIT_RESOLVER_COUNTER_HIT_EN
    assign counter_p1 = is_startup(STATE_P1);
    assign counter_p2 = is_startup(STATE_P2);
`else
    assign counter_p1 = 1'b0;
    assign counter_p2 = 1'b0;
`endif

    function automatic logic [4:0] stun_for(input logic blocked, input logic counter);
        if (blocked)
            return BLOCK_STUN;
        if (counter)
            return sat_add5(HIT_STUN, COUNTER_BONUS);
        return HIT_STUN;
    endfunction

    assign stun_p1 = stun_for(BLOCK_P1, counter_p1);
    assign stun_p2 = stun_for(BLOCK_P2, counter_p2);

    // Only unblocked hits cost health; zero is sticky.
    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        health_p1_nxt = HEALTH_P1;
        health_p2_nxt = HEALTH_P2;
        if (hit_on_p1 && !BLOCK_P1 && (HEALTH_P1 != 2'd0))
            health_p1_nxt = HEALTH_P1 - 2'd1;
        if (hit_on_p2 && !BLOCK_P2 && (HEALTH_P2 != 2'd0))
            health_p2_nxt = HEALTH_P2 - 2'd1;
    end

    // Stun outputs are one-cycle pulses: hit_done blocks a second hit next cycle.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            LOAD_FRAME_P1 <= 5'd0;
            LOAD_FRAME_P2 <= 5'd0;
            HEALTH_P1     <= MAX_HEALTH;
            HEALTH_P2     <= MAX_HEALTH;
        end else begin
            LOAD_FRAME_P1 <= hit_on_p1 ? stun_p1 : 5'd0;
            LOAD_FRAME_P2 <= hit_on_p2 ? stun_p2 : 5'd0;
            HEALTH_P1     <= health_p1_nxt;
            HEALTH_P2     <= health_p2_nxt;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)
            state <= G_RUN;
        else
            state <= state_nxt;
    end

    // Looking at next-cycle health makes OVER coincide with the killing decrement.
    always_comb begin
        state_nxt = state;
        if ((state == G_RUN) && ((health_p1_nxt == 2'd0) || (health_p2_nxt == 2'd0)))
            state_nxt = G_OVER;
    end

    always_comb begin
        GAME_OVER = 1'b0;
        WINNER    = WIN_NONE;
        if (state == G_OVER) begin
            GAME_OVER = 1'b1;
            if ((HEALTH_P1 == 2'd0) && (HEALTH_P2 == 2'd0))
                WINNER = WIN_DRAW;
            else if (HEALTH_P1 == 2'd0)
                WINNER = WIN_P2;
            else
                WINNER = WIN_P1;
        end
    end

endmodule
